// File: rtl/pwm_capture.sv
// pwm_capture: PWM high-time and period capture behind a 5-register CSR window.
// Optional 3-sample input glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter logic [4:0] BASE_ADDR = 5'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic       pwm_ce,
  input  logic       pwm_in
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } state_t;

  localparam logic [4:0] A_CTRL = BASE_ADDR;
  localparam logic [4:0] A_HTL  = BASE_ADDR + 5'd1;
  localparam logic [4:0] A_HTH  = BASE_ADDR + 5'd2;
  localparam logic [4:0] A_PRL  = BASE_ADDR + 5'd3;
  localparam logic [4:0] A_PRH  = BASE_ADDR + 5'd4;

  state_t      state;
  logic [1:0]  sync_q;
  logic        lvl;
  logic        lvl_nxt;
  logic        rise;
  logic        fall;
  logic        en;
  logic        freeze;
  logic        valid;
  logic        timeout;
  logic [15:0] cnt;
  logic [15:0] hcnt;
  logic [15:0] high_time;
  logic [15:0] period;
  logic [15:0] cnt_inc;
  logic        cnt_max;
  logic        ctrl_wr;
  logic        en_off;
  logic [7:0]  rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= 2'b00;
    end else if (pwm_ce) begin
      hist <= {hist[0], sync_q[1]};
    end
  end

  // level only moves once three consecutive samples agree
  always_comb begin
    lvl_nxt = lvl;
    if (sync_q[1] == hist[0] && sync_q[1] == hist[1]) begin
      lvl_nxt = sync_q[1];
    end
  end
`else
  assign lvl_nxt = sync_q[1];
`endif

  assign rise    = pwm_ce & lvl_nxt & ~lvl;
  assign fall    = pwm_ce & ~lvl_nxt & lvl;
  assign cnt_max = (cnt == 16'hFFFF);
  assign cnt_inc = cnt_max ? cnt : cnt + 16'd1;
  assign ctrl_wr = csr_we && (csr_a == A_CTRL);
  assign en_off  = ctrl_wr && !csr_di[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lvl       <= 1'b0;
      en        <= 1'b0;
      freeze    <= 1'b0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      cnt       <= 16'h0000;
      hcnt      <= 16'h0000;
      high_time <= 16'h0000;
      period    <= 16'h0000;
    end else begin
      if (pwm_ce) begin
        lvl <= lvl_nxt;
      end
      if (ctrl_wr) begin
        en     <= csr_di[7];
        freeze <= csr_di[0];
        if (csr_di[6]) valid <= 1'b0;
        if (csr_di[5]) timeout <= 1'b0;
      end
      // status sets below override the clears above
      if (!en || en_off) begin
        state <= IDLE;
        cnt   <= 16'h0000;
        hcnt  <= 16'h0000;
      end else if (pwm_ce) begin
        unique case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (rise) begin
              state <= HIGH;
              cnt   <= 16'd1;
            end
          end
          HIGH: begin
            if (fall) begin
              state <= LOW;
              hcnt  <= cnt;
              cnt   <= cnt_inc;
            end else if (cnt_max) begin
              state   <= ARM;
              cnt     <= 16'h0000;
              timeout <= 1'b1;
              if (!freeze) begin
                high_time <= {16{lvl}};
                period    <= 16'h0000;
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
          LOW: begin
            if (rise) begin
              state <= HIGH;
              cnt   <= 16'd1;
              valid <= 1'b1;
              if (!freeze) begin
                high_time <= hcnt;
                period    <= cnt;
              end
            end else if (cnt_max) begin
              state   <= ARM;
              cnt     <= 16'h0000;
              timeout <= 1'b1;
              if (!freeze) begin
                high_time <= {16{lvl}};
                period    <= 16'h0000;
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    rd_data = 8'h00;
    unique case (1'b1)
      csr_a == A_CTRL: rd_data = {en, valid, timeout, lvl, 3'b000, freeze};
      csr_a == A_HTL:  rd_data = high_time[7:0];
      csr_a == A_HTH:  rd_data = high_time[15:8];
      csr_a == A_PRL:  rd_data = period[7:0];
      csr_a == A_PRH:  rd_data = period[15:8];
      default:         rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csr_do <= 8'h00;
    end else begin
      csr_do <= rd_data;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench; expected capture values come from
// run-length analysis of the driven waveform.
module tb_pwm_capture;

  localparam logic [4:0] BASE = 5'h0A;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int EDGE_LAT = 5;
`else
  localparam int EDGE_LAT = 3;
`endif

  typedef struct {
    bit lv;
    int n;
  } seg_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;
  logic       pwm_ce;
  logic       pwm_in;

  logic       rd_req;
  logic       rd_seen = 1'b0;
  logic       done;
  logic [7:0] exp_q[$];
  string      nm_q[$];
  seg_t       seg_q[$];
  int         total = 0;
  int         bad = 0;

  pwm_capture #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .rst    (rst),
    .csr_a  (csr_a),
    .csr_di (csr_di),
    .csr_we (csr_we),
    .csr_do (csr_do),
    .pwm_ce (pwm_ce),
    .pwm_in (pwm_in)
  );

  always #5 clk = ~clk;

  task automatic step();
    int k;
    k = seg_q.size();
    if (k > 0 && seg_q[k-1].lv == pwm_in) begin
      seg_q[k-1].n = seg_q[k-1].n + 1;
    end else begin
      seg_q.push_back('{pwm_in, 1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit lv, input int n);
    pwm_in = lv;
    repeat (n) step();
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    csr_a  = BASE + 5'(off);
    csr_di = d;
    csr_we = 1'b1;
    step();
    csr_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off, input logic [7:0] e, input string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    csr_a  = BASE + 5'(off);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  // last full period = the high run and low run before the final rise
  function automatic void model(output logic [15:0] ht, output logic [15:0] per);
    seg_t r[$];
    int   i;
    r = seg_q;
    i = 1;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    while (i + 1 < r.size()) begin
      if (r[i].n < 3) begin
        r[i-1].n = r[i-1].n + r[i].n + r[i+1].n;
        r.delete(i + 1);
        r.delete(i);
      end else begin
        i++;
      end
    end
`endif
    ht  = 16'(r[r.size()-3].n);
    per = 16'(r[r.size()-3].n + r[r.size()-2].n);
  endfunction

  task automatic rd_all(input logic [15:0] ht, input logic [15:0] per,
                        input logic [7:0] ctrl, input string nm);
    rd(3'd1, ht[7:0], {nm, ".ht_lo"});
    rd(3'd2, ht[15:8], {nm, ".ht_hi"});
    rd(3'd3, per[7:0], {nm, ".per_lo"});
    rd(3'd4, per[15:8], {nm, ".per_hi"});
    rd(3'd0, ctrl, {nm, ".ctrl"});
  endtask

  always @(posedge clk) rd_seen <= rd_req;

  always @(negedge clk) begin
    logic [7:0] e;
    string      n;
    if (rd_seen) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_read: got %02h, nothing expected", csr_do);
      end else begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        if (csr_do !== e) begin
          bad++;
          $display("FAIL %s: got %02h want %02h", n, csr_do, e);
        end
      end
    end
    if (done) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    logic [15:0] ht;
    logic [15:0] per;
    logic [15:0] sh;
    logic [15:0] sp;
    int h;
    int l;
    rst    = 1'b1;
    csr_a  = 5'h0;
    csr_di = 8'h00;
    csr_we = 1'b0;
    pwm_ce = 1'b1;
    pwm_in = 1'b0;
    rd_req = 1'b0;
    done   = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      rd(3'(i), 8'h00, $sformatf("reset.addr%0d", i));
    end

    wr(3'd0, 8'h80);
    seg_q.delete();
    drive(0, 10);
    drive(1, 30);
    drive(0, 70);
    drive(1, 30);
    drive(0, 70);
    drive(1, 5);
    model(ht, per);
    rd_all(ht, per, 8'hD0, "basic");
    sh = ht;
    sp = per;

    wr(3'd0, 8'h81);
    drive(0, 20);
    drive(1, 10);
    drive(0, 20);
    drive(1, 10);
    drive(0, 20);
    drive(1, 5);
    rd_all(sh, sp, 8'hD1, "freeze");

    wr(3'd0, 8'h80);
    drive(0, 20);
    drive(1, 10);
    drive(0, 20);
    drive(1, 5);
    model(ht, per);
    rd_all(ht, per, 8'hD0, "unfreeze");
    wr(3'd0, 8'hC0);
    rd(3'd0, 8'h90, "w1c_valid");

    for (int t = 0; t < 6; t++) begin
      h = int'($urandom_range(300, 3));
      l = int'($urandom_range(300, 3));
      seg_q.delete();
      drive(0, int'($urandom_range(100, 3)));
      drive(1, h);
      drive(0, l);
      drive(1, 5);
      model(ht, per);
      rd_all(ht, per, 8'hD0, $sformatf("rand%0d", t));
      wr(3'd0, 8'hC0);
    end

    seg_q.delete();
    drive(1, 70000);
    rd_all(16'hFFFF, 16'h0000, 8'hB0, "timeout");
    wr(3'd0, 8'hA0);
    rd(3'd0, 8'h90, "timeout_clr");

    seg_q.delete();
    drive(0, 20);
    drive(1, 10);
    wr(3'd0, 8'hC0);
    drive(0, 20);
    pwm_in = 1'b1;
    repeat (EDGE_LAT - 1) step();
    wr(3'd0, 8'hC0);
    drive(1, 3);
    model(ht, per);
    rd_all(ht, per, 8'hD0, "set_vs_clr");

    seg_q.delete();
    drive(0, 20);
    drive(1, 14);
    drive(0, 1);
    drive(1, 15);
    drive(0, 20);
    drive(1, 5);
    model(ht, per);
    rd_all(ht, per, 8'hD0, "glitch");

    drive(0, 20);
    drive(1, 30);
    drive(0, 10);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    drive(1, 20);
    drive(0, 20);
    drive(1, 20);
    drive(0, 10);
    for (int i = 0; i < 5; i++) begin
      rd(3'(i), 8'h00, $sformatf("midrst.addr%0d", i));
    end

    done = 1'b1;
    repeat (4) step();
    $display("FAIL summary_not_reached: got no summary want summary");
    $fatal(1, "monitor did not finish");
  end

endmodule
